// File: rtl/display_pkg.sv
// Shared types and constants for the display arbiter slice.
// The state enum is used by display_arbiter; the constants describe display_unit's interface.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_GAP
    } state_t;

    localparam int         VALUE_W = 8;
    localparam logic [7:0] COM_OFF = 8'hFF;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: finds the first asserted request
// starting at rr_ptr and wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               any,
    output logic [ID_W-1:0]    win_id
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        any    = |req;
        win_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                win_id = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of the shared 7-segment display with a minimum hold
// time per owner and a blanking gap between owners. All outputs registered.
module display_arbiter
    import display_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 1000,
    parameter int GAP_CYCLES  = 4,
    parameter int CNT_W       = 16,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [VALUE_W*NUM_REQ-1:0] req_value,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic [ID_W-1:0]          owner_id,
    output logic                     disp_enable,
    output logic [VALUE_W-1:0]       disp_value
);

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic [ID_W-1:0]      rr_ptr, rr_ptr_nx;
    logic [NUM_REQ-1:0]   grant_nx;
    logic                 busy_nx;
    logic [ID_W-1:0]      owner_nx;
    logic                 en_nx;
    logic [VALUE_W-1:0]   value_nx;

    logic                 pick_any;
    logic [ID_W-1:0]      pick_id;
    logic [VALUE_W-1:0]   vals [NUM_REQ];
    logic [NUM_REQ-1:0]   owner_mask;
    logic                 owner_req;
    logic                 others_req;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .win_id (pick_id)
    );

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_vals
        assign vals[g] = req_value[g*VALUE_W +: VALUE_W];
    end

    assign owner_mask = NUM_REQ'(1) << owner_id;
    assign owner_req  = req[owner_id];
    assign others_req = |(req & ~owner_mask);

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        rr_ptr_nx = rr_ptr;
        grant_nx  = grant;
        busy_nx   = busy;
        owner_nx  = owner_id;
        en_nx     = disp_enable;
        value_nx  = disp_value;

        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nx  = ST_SHOW;
                    grant_nx  = NUM_REQ'(1) << pick_id;
                    owner_nx  = pick_id;
                    rr_ptr_nx = ID_W'((int'(pick_id) + 1) % NUM_REQ);
                    cnt_nx    = CNT_W'(HOLD_CYCLES - 1);
                    en_nx     = 1'b1;
                    busy_nx   = 1'b1;
                    value_nx  = '0;
                end
            end
            ST_SHOW: begin
                // Early release wins over everything; preemption only once the hold has expired.
                if (!owner_req || (cnt == '0 && others_req)) begin
                    state_nx = ST_GAP;
                    grant_nx = '0;
                    en_nx    = 1'b0;
                    value_nx = '0;
                    cnt_nx   = CNT_W'(GAP_CYCLES - 1);
                    busy_nx  = 1'b1;
                end else begin
                    value_nx = vals[owner_id];
                    if (cnt != '0) begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_nx = ST_IDLE;
                    busy_nx  = 1'b0;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                grant_nx = '0;
                en_nx    = 1'b0;
                value_nx = '0;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rr_ptr      <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            owner_id    <= '0;
            disp_enable <= 1'b0;
            disp_value  <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            rr_ptr      <= rr_ptr_nx;
            grant       <= grant_nx;
            busy        <= busy_nx;
            owner_id    <= owner_nx;
            disp_enable <= en_nx;
            disp_value  <= value_nx;
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter against an ownership-level reference model.
module tb_display_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 10;
    localparam int GAP  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_value;
    logic [3:0]  grant;
    logic        busy;
    logic [1:0]  owner_id;
    logic        disp_enable;
    logic [7:0]  disp_value;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the display, how long it has shown, how long we've been blank.
    bit       m_showing;
    int       m_owner;
    int       m_held;
    int       m_blank;
    int       m_next;
    logic [7:0] m_val;

    always #5 clk = ~clk;

    display_arbiter #(
        .NUM_REQ     (N),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP),
        .CNT_W       (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_value   (req_value),
        .grant       (grant),
        .busy        (busy),
        .owner_id    (owner_id),
        .disp_enable (disp_enable),
        .disp_value  (disp_value)
    );

    task automatic model_reset();
        m_showing = 0;
        m_owner   = 0;
        m_held    = 0;
        m_blank   = GAP + 1;
        m_next    = 0;
        m_val     = 8'd0;
    endtask

    task automatic model_step();
        bit others;
        if (rst) begin
            model_reset();
        end else if (m_showing) begin
            others = 0;
            for (int j = 0; j < N; j++) if (j != m_owner && req[j]) others = 1;
            if (!req[m_owner] || (m_held >= HOLD && others)) begin
                m_showing = 0;
                m_blank   = 1;
                m_val     = 8'd0;
            end else begin
                m_held++;
                m_val = req_value[m_owner*8 +: 8];
            end
        end else if (m_blank <= GAP) begin
            m_blank++;
        end else if (req != 4'b0000) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_next + k) % N;
                if (!m_showing && req[i]) begin
                    m_owner   = i;
                    m_next    = (i + 1) % N;
                    m_showing = 1;
                    m_held    = 1;
                    m_val     = 8'd0;
                end
            end
        end
    endtask

    function automatic logic [15:0] exp_vec();
        logic [3:0] g;
        g = m_showing ? (4'b0001 << m_owner) : 4'b0000;
        return {g, (m_showing || m_blank <= GAP), 2'(m_owner), m_showing, m_val};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req       = 4'b0000;
        req_value = 32'd0;
        do_reset();
        req = 4'b0001;
        req_value[7:0] = 8'd55;
        for (int c = 0; c < 4; c++) step();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if ({grant, busy, owner_id, disp_enable, disp_value} !== 16'h0000) begin
                errors++;
                $display("[TB] FAIL reset_state cyc%0d: got g=%b b=%b o=%0d en=%b v=%0d, want all zero",
                         c, grant, busy, owner_id, disp_enable, disp_value);
            end
        end
        rst = 1'b0;
        req = 4'b0000;
    endtask

    task automatic test_latency();
        do_reset();
        req = 4'b0100;
        req_value[23:16] = 8'd123;
        step();
        checks++;
        if (grant !== 4'b0100 || disp_enable !== 1'b1 || owner_id !== 2'd2) begin
            errors++;
            $display("[TB] FAIL grant_latency: got g=%b en=%b o=%0d, want g=0100 en=1 o=2",
                     grant, disp_enable, owner_id);
        end
        step();
        checks++;
        if (disp_value !== 8'd123) begin
            errors++;
            $display("[TB] FAIL value_lag: got %0d, want 123", disp_value);
        end
        req = 4'b0000;
    endtask

    task automatic test_alternate();
        logic [3:0] want;
        do_reset();
        req = 4'b0011;
        for (int c = 0; c < 75; c++) begin
            step();
            want = ((c % 15) < HOLD) ? (4'b0001 << ((c / 15) % 2)) : 4'b0000;
            checks++;
            if (grant !== want || disp_enable !== (want != 4'b0000)) begin
                errors++;
                $display("[TB] FAIL alternate cyc%0d: got g=%b en=%b, want g=%b", c, grant, disp_enable, want);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_early_release();
        bit r3;
        do_reset();
        req = 4'b0100;
        step();
        step();
        step();
        r3 = 1'($urandom_range(0, 1));
        req = {r3, 3'b001};
        step();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b1 || disp_enable !== 1'b0) begin
            errors++;
            $display("[TB] FAIL early_release: got g=%b b=%b en=%b, want g=0000 b=1 en=0", grant, busy, disp_enable);
        end
        for (int c = 0; c < GAP + 1; c++) begin
            step();
            checks++;
            if ({grant, busy, owner_id, disp_enable, disp_value} !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL release_gap cyc%0d: got %h, want %h", c,
                         {grant, busy, owner_id, disp_enable, disp_value}, exp_vec());
            end
        end
        checks++;
        if (grant !== (r3 ? 4'b1000 : 4'b0001)) begin
            errors++;
            $display("[TB] FAIL next_after_release: got g=%b, want %b", grant, r3 ? 4'b1000 : 4'b0001);
        end
        req = 4'b0000;
    endtask

    task automatic test_single_long();
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < 2000; c++) begin
            req_value[15:8] = 8'($urandom);
            step();
            checks++;
            if (grant !== 4'b0010 || disp_enable !== 1'b1 ||
                {grant, busy, owner_id, disp_enable, disp_value} !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL single_hold cyc%0d: got g=%b en=%b v=%0d, want g=0010 en=1 v=%0d",
                         c, grant, disp_enable, disp_value, m_val);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_all_four();
        int order[5];
        int seen;
        logic [3:0] prev;
        do_reset();
        req  = 4'b1111;
        seen = 0;
        prev = 4'b0000;
        for (int c = 0; c < 200 && seen < 5; c++) begin
            step();
            checks++;
            if (!$onehot0(grant) || disp_enable !== (grant != 4'b0000)) begin
                errors++;
                $display("[TB] FAIL all_onehot cyc%0d: got g=%b en=%b", c, grant, disp_enable);
            end
            if (grant != 4'b0000 && prev == 4'b0000) begin
                order[seen] = int'(owner_id);
                seen++;
            end
            prev = grant;
        end
        checks++;
        if (seen != 5) begin
            errors++;
            $display("[TB] FAIL all_timeout: got %0d grants, want 5", seen);
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (order[k] != (k % 4)) begin
                    errors++;
                    $display("[TB] FAIL all_order[%0d]: got %0d, want %0d", k, order[k], k % 4);
                end
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int j = 0; j < N; j++) if ($urandom_range(0, 15) == 0) req[j] = ~req[j];
            req_value = $urandom;
            rst = ($urandom_range(0, 499) == 0);
            step();
            checks++;
            if ({grant, busy, owner_id, disp_enable, disp_value} !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL random cyc%0d: got g=%b b=%b o=%0d en=%b v=%0d, want %h",
                         c, grant, busy, owner_id, disp_enable, disp_value, exp_vec());
            end
        end
        rst = 1'b0;
        req = 4'b0000;
    endtask

    initial begin
        rst       = 1'b1;
        req       = 4'b0000;
        req_value = 32'd0;
        model_reset();
        test_reset();
        test_latency();
        test_alternate();
        test_early_release();
        test_single_long();
        test_all_four();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
